tag_slot_scheduler: RTL and testbench
=====================================

Name: tag_slot_scheduler

Overview:
Parametrised TDMA scheduler for backscatter tags. It gives each of NUM_TAGS tags an exclusive time slot, and during that slot it gates a selectable subcarrier (clk_40 or clk_80) onto that tag's output. Slot timing derives from a programmable tick divider on clk_1000. It supports enable masks, per-tag subcarrier mode, guard intervals, finite or continuous round counts, and start/stop/done control for the top-level measurement sequencer.

Parameters:
NUM_TAGS, 3, number of tag channels (>=1)
TAG_W, 2, width of active_tag; must satisfy 2**TAG_W >= NUM_TAGS
DIV_N, 2000, clk_1000 cycles per tick (>=2); 2 ms tick at 1 MHz
SLOT_TICKS, 25, ticks per active slot (>=1); 50 ms default
GUARD_TICKS, 1, idle ticks after every slot, all outputs low (0 allowed)
ROUNDS_W, 8, width of num_rounds/round_cnt

Ports:
clk_1000  in  1  scheduler clock
rst_n  in  1  async active-low reset
clk_40  in  1  subcarrier A
clk_80  in  1  subcarrier B
start  in  1  single-cycle start request
stop  in  1  synchronous abort
continuous  in  1  1 = run rounds indefinitely
num_rounds  in  ROUNDS_W  rounds per run when continuous=0; 0 treated as 1
tag_en  in  NUM_TAGS  per-tag enable mask
mode_sel  in  NUM_TAGS  per-tag subcarrier: 0 = clk_40, 1 = clk_80
tag_out  out  NUM_TAGS  gated subcarrier per tag
active_tag  out  TAG_W  index of tag in current slot; 0 when idle
slot_strobe  out  1  one-cycle pulse on the first cycle of each SLOT
busy  out  1  high in SLOT or GUARD
done  out  1  one-cycle pulse when a finite run completes
round_cnt  out  ROUNDS_W  completed rounds in the current run

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk_1000. On reset: state IDLE, divider/tick/round counters 0, latched mask/mode 0, gate register 0, all outputs 0.
- Divider: counts 0..DIV_N-1 only outside IDLE; tick = (div_cnt==DIV_N-1). Cleared on entry to SLOT from IDLE.
- FSM states: IDLE, SLOT, GUARD.
- IDLE:
  - start=1 with tag_en!=0 and stop=0: latch tag_en, mode_sel and round target (max(num_rounds,1)).
  - Clear round_cnt; active_tag = lowest enabled index; go to SLOT.
  - start with tag_en==0 is ignored.
- SLOT: lasts exactly SLOT_TICKS*DIV_N cycles, then goes to GUARD (if GUARD_TICKS>0) or advances directly.
- GUARD: lasts GUARD_TICKS*DIV_N cycles; all gates low.
- Advance:
  - Move to the next enabled index above active_tag (latched mask).
  - If none remains, the round is complete: round_cnt++ (wraps modulo 2**ROUNDS_W).
  - If continuous=0 and the incremented count equals the target: go to IDLE, pulse done, active_tag=0, round_cnt holds its final value.
  - Otherwise wrap to the lowest enabled index and enter SLOT.
  - continuous is sampled live at each round end.
- Gating:
  - gate_q[i] is a registered one-hot, high only in SLOT for i=active_tag; it rises one cycle after entering SLOT.
  - tag_out[i] = gate_q[i] & (mode_q[i] ? clk_80 : clk_40), combinational from the registered gate.
- slot_strobe: registered, coincident with the first gate_q-high cycle of each slot.
- stop=1 in any non-IDLE state: next edge goes to IDLE, gates drop, no done pulse, round_cnt holds.
- stop and start in the same cycle in IDLE: stop wins.
- start while busy: ignored.
- tag_en/mode_sel changes mid-run: ignored until the next start.
- Reset mid-run: immediate return to reset values, including tag_out low.

Test Plan:
Use DIV_N=4, SLOT_TICKS=3, GUARD_TICKS=1, NUM_TAGS=3.
1. Reset release, no start -> tag_out=000, busy=0, done=0, round_cnt=0 indefinitely.
2. tag_en=111, mode_sel=000, num_rounds=1, continuous=0, start pulse at cycle 0:
   - tag_out[0] follows clk_40 for 12 cycles, then 4 low cycles.
   - tag1 and tag2 follow the same pattern.
   - done pulses at cycle 48; round_cnt=1; busy=0 after.
   - slot_strobe fires 3 times, 16 cycles apart.
3. tag_en=101, mode_sel=100, num_rounds=2:
   - Tag1 is never driven; tag2 carries clk_80.
   - Sequence is 0,2,0,2; done after 64 cycles; round_cnt=2.
4. continuous=1, tag_en=010: tag1 slots repeat every 16 cycles, round_cnt increments each 16 cycles, done never asserts. With ROUNDS_W=2, round_cnt wraps 3->0.
5. stop asserted at cycle 5 of a slot -> next edge busy=0, tag_out=000, no done; a new start restarts from the lowest enabled tag with round_cnt=0.
6. Start with tag_en=000 -> remains IDLE. start+stop same cycle -> remains IDLE. Toggle mode_sel mid-run -> output subcarrier unchanged until the next start.

Source files
------------

// File: rtl/tag_slot_scheduler.sv
// TDMA slot scheduler for backscatter tags. Each enabled tag gets an
// exclusive slot in which its chosen subcarrier is gated onto its output,
// followed by an optional all-low guard interval.
`timescale 1ns/1ps

module tag_slot_scheduler #(
  parameter int unsigned NUM_TAGS    = 3,
  parameter int unsigned TAG_W       = 2,
  parameter int unsigned DIV_N       = 2000,
  parameter int unsigned SLOT_TICKS  = 25,
  parameter int unsigned GUARD_TICKS = 1,
  parameter int unsigned ROUNDS_W    = 8
) (
  input  logic                clk_1000,
  input  logic                rst_n,
  input  logic                clk_40,
  input  logic                clk_80,
  input  logic                start,
  input  logic                stop,
  input  logic                continuous,
  input  logic [ROUNDS_W-1:0] num_rounds,
  input  logic [NUM_TAGS-1:0] tag_en,
  input  logic [NUM_TAGS-1:0] mode_sel,
  output logic [NUM_TAGS-1:0] tag_out,
  output logic [TAG_W-1:0]    active_tag,
  output logic                slot_strobe,
  output logic                busy,
  output logic                done,
  output logic [ROUNDS_W-1:0] round_cnt
);

  localparam int unsigned DIV_W     = (DIV_N > 1) ? $clog2(DIV_N) : 1;
  localparam int unsigned MAX_TICKS = (SLOT_TICKS > GUARD_TICKS) ? SLOT_TICKS : GUARD_TICKS;
  localparam int unsigned TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DIV_N - 1);
  localparam logic [TICK_W-1:0] SLOT_LAST  = TICK_W'(SLOT_TICKS - 1);
  localparam logic [TICK_W-1:0] GUARD_LAST = TICK_W'((GUARD_TICKS > 0) ? GUARD_TICKS - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SLOT,
    ST_GUARD
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [NUM_TAGS-1:0]   mask_q, mask_d;
  logic [NUM_TAGS-1:0]   mode_q, mode_d;
  logic [ROUNDS_W-1:0]   target_q, target_d;
  logic [ROUNDS_W-1:0]   round_q, round_d;
  logic [ROUNDS_W-1:0]   round_inc;
  logic [NUM_TAGS-1:0]   gate_q;
  logic                  strobe_q;
  logic                  done_q, done_d;
  logic                  tick;
  logic                  advance;
  logic [TAG_W:0]        start_hit, next_hit, first_hit;
  logic [NUM_TAGS-1:0]   slot_onehot;

  // Lowest enabled index at or above 'first'; MSB flags whether one exists.
  function automatic logic [TAG_W:0] find_enabled(input logic [NUM_TAGS-1:0] mask,
                                                  input int unsigned         first);
    logic [TAG_W:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      if (!r[TAG_W] && (i >= first) && mask[i]) begin
        r = {1'b1, TAG_W'(i)};
      end
    end
    return r;
  endfunction

  // Next-state logic: divider, tick counting, slot sequencing and round accounting.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    tick_d    = tick_q;
    tag_d     = tag_q;
    mask_d    = mask_q;
    mode_d    = mode_q;
    target_d  = target_q;
    round_d   = round_q;
    done_d    = 1'b0;
    advance   = 1'b0;
    tick      = (div_q == DIV_LAST);
    round_inc = round_q + 1'b1;
    start_hit = find_enabled(tag_en, 0);
    next_hit  = find_enabled(mask_q, 32'(tag_q) + 32'd1);
    first_hit = find_enabled(mask_q, 0);

    case (state_q)
      ST_IDLE: begin
        if (start && !stop && start_hit[TAG_W]) begin
          state_d  = ST_SLOT;
          mask_d   = tag_en;
          mode_d   = mode_sel;
          target_d = (num_rounds == '0) ? ROUNDS_W'(1) : num_rounds;
          round_d  = '0;
          tag_d    = start_hit[TAG_W-1:0];
          div_d    = '0;
          tick_d   = '0;
        end
      end
      ST_SLOT: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          if (tick_q == SLOT_LAST) begin
            tick_d = '0;
            if (GUARD_TICKS > 0) state_d = ST_GUARD;
            else                 advance = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_GUARD: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          if (tick_q == GUARD_LAST) begin
            tick_d  = '0;
            advance = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (next_hit[TAG_W]) begin
        tag_d   = next_hit[TAG_W-1:0];
        state_d = ST_SLOT;
      end else begin
        round_d = round_inc;
        if (!continuous && (round_inc == target_q)) begin
          state_d = ST_IDLE;
          tag_d   = '0;
          div_d   = '0;
          done_d  = 1'b1;
        end else begin
          tag_d   = first_hit[TAG_W-1:0];
          state_d = first_hit[TAG_W] ? ST_SLOT : ST_IDLE;
        end
      end
    end

    // Abort overrides any slot/round transition in the same cycle.
    if ((state_q != ST_IDLE) && stop) begin
      state_d = ST_IDLE;
      tag_d   = '0;
      div_d   = '0;
      tick_d  = '0;
      round_d = round_q;
      done_d  = 1'b0;
    end
  end

  assign slot_onehot = NUM_TAGS'(1) << tag_q;

  // State and datapath registers.
  always_ff @(posedge clk_1000 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      tick_q   <= '0;
      tag_q    <= '0;
      mask_q   <= '0;
      mode_q   <= '0;
      target_q <= '0;
      round_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      tag_q    <= tag_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      target_q <= target_d;
      round_q  <= round_d;
      done_q   <= done_d;
    end
  end

  // Gate and strobe lag the state by one cycle, so the gate spans exactly
  // the slot length and drops on the same edge that a stop takes effect.
  always_ff @(posedge clk_1000 or negedge rst_n) begin
    if (!rst_n) begin
      gate_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      gate_q   <= ((state_q == ST_SLOT) && !stop) ? slot_onehot : '0;
      strobe_q <= (state_q == ST_SLOT) && (div_q == '0) && (tick_q == '0) && !stop;
    end
  end

  assign tag_out     = gate_q & ((mode_q & {NUM_TAGS{clk_80}}) | (~mode_q & {NUM_TAGS{clk_40}}));
  assign active_tag  = tag_q;
  assign slot_strobe = strobe_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign round_cnt   = round_q;

endmodule

// File: tb/tb_tag_slot_scheduler.sv
// Bench for tag_slot_scheduler with DIV_N=4, SLOT_TICKS=3, GUARD_TICKS=1,
// so every slot+guard period is 16 cycles (12 gated, 4 low).
`timescale 1ns/1ps

module tb_tag_slot_scheduler;

  localparam int NT = 3;
  localparam int TW = 2;
  localparam int RW = 2;

  logic          clk_1000 = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_40 = 1'b0;
  logic          clk_80 = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          continuous = 1'b0;
  logic [RW-1:0] num_rounds = '0;
  logic [NT-1:0] tag_en = '0;
  logic [NT-1:0] mode_sel = '0;
  logic [NT-1:0] tag_out;
  logic [TW-1:0] active_tag;
  logic          slot_strobe;
  logic          busy;
  logic          done;
  logic [RW-1:0] round_cnt;

  tag_slot_scheduler #(
    .NUM_TAGS(NT), .TAG_W(TW), .DIV_N(4), .SLOT_TICKS(3), .GUARD_TICKS(1), .ROUNDS_W(RW)
  ) dut (
    .clk_1000(clk_1000), .rst_n(rst_n), .clk_40(clk_40), .clk_80(clk_80),
    .start(start), .stop(stop), .continuous(continuous), .num_rounds(num_rounds),
    .tag_en(tag_en), .mode_sel(mode_sel), .tag_out(tag_out), .active_tag(active_tag),
    .slot_strobe(slot_strobe), .busy(busy), .done(done), .round_cnt(round_cnt)
  );

  // Edges of clk_1000 fall on 0/5 mod 10; subcarriers toggle on 2 and 7 mod 10.
  always #5 clk_1000 = ~clk_1000;
  initial begin #2; forever #20 clk_40 = ~clk_40; end
  initial begin #7; forever #10 clk_80 = ~clk_80; end

  typedef struct {
    logic [NT-1:0] gate;
    logic [NT-1:0] mode;
    logic [TW-1:0] act;
    logic          strobe;
    logic          busy;
    logic          done;
    logic [RW-1:0] rc;
  } exp_t;

  typedef struct {
    logic [NT-1:0] en;
    logic [NT-1:0] mode;
    logic [NT-1:0] en_mid;
    logic [RW-1:0] nr;
    logic          cont;
    int            run_cycles;
    int            slots;
    int            exp_rc;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   last_rc = 0;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Compare DUT outputs against the oldest queued expectation.
  always @(negedge clk_1000) begin
    exp_t          e;
    logic [NT-1:0] want_out;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      want_out = e.gate & ((e.mode & {NT{clk_80}}) | (~e.mode & {NT{clk_40}}));
      chk("tag_out",     8'(tag_out),     8'(want_out));
      chk("active_tag",  8'(active_tag),  8'(e.act));
      chk("slot_strobe", 8'(slot_strobe), 8'(e.strobe));
      chk("busy",        8'(busy),        8'(e.busy));
      chk("done",        8'(done),        8'(e.done));
      chk("round_cnt",   8'(round_cnt),   8'(e.rc));
    end
  end

  function automatic exp_t idle_exp(input int rc, input logic d);
    exp_t e;
    e.gate = '0; e.mode = '0; e.act = '0; e.strobe = 1'b0;
    e.busy = 1'b0; e.done = d; e.rc = RW'(rc);
    return e;
  endfunction

  task automatic cycle(input exp_t e);
    @(posedge clk_1000);
    #1;
    sb.push_back(e);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) cycle(idle_exp(last_rc, 1'b0));
  endtask

  // abort: 0 = let run finish, 1 = stop after run_cycles, 2 = reset after run_cycles
  task automatic run_case(input vec_t v, input int abort);
    int   order[$];
    int   p;
    exp_t e;
    for (int i = 0; i < NT; i++) if (v.en[i]) order.push_back(i);
    p = order.size();
    tag_en = v.en; mode_sel = v.mode; num_rounds = v.nr; continuous = v.cont;
    start = 1'b1;
    for (int n = 0; n < v.run_cycles; n++) begin
      if (v.slots == 0 || n < 16 * v.slots) begin
        e.mode   = v.mode;
        e.busy   = 1'b1;
        e.done   = 1'b0;
        e.act    = TW'(order[(n / 16) % p]);
        e.gate   = (n >= 1 && ((n - 1) % 16) < 12) ? NT'(1) << order[((n - 1) / 16) % p] : '0;
        e.strobe = (n >= 1 && ((n - 1) % 16) == 0);
        e.rc     = RW'((n / (16 * p)) % 4);
        last_rc  = (n / (16 * p)) % 4;
      end else begin
        e = idle_exp(v.exp_rc, n == 16 * v.slots);
        last_rc = v.exp_rc;
      end
      cycle(e);
      start = (n == 6);
      if (n == 4) begin
        tag_en = v.en_mid;
        mode_sel = ~v.mode;
      end
    end
    start = 1'b0;
    if (abort == 1) begin
      stop = 1'b1;
      cycle(idle_exp(last_rc, 1'b0));
      stop = 1'b0;
    end else if (abort == 2) begin
      @(negedge clk_1000);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_tag_out",   8'(tag_out),   8'h00);
      chk("rst_busy",      8'(busy),      8'h00);
      chk("rst_round_cnt", 8'(round_cnt), 8'h00);
      chk("rst_active",    8'(active_tag), 8'h00);
      last_rc = 0;
      cycle(idle_exp(0, 1'b0));
      #2;
      rst_n = 1'b1;
    end
  endtask

  initial begin
    vec_t s;
    tbl[0] = '{3'b111, 3'b000, 3'b010, 2'd1, 1'b0, 51, 3, 1};
    tbl[1] = '{3'b101, 3'b100, 3'b011, 2'd2, 1'b0, 67, 4, 2};
    tbl[2] = '{3'b001, 3'b001, 3'b110, 2'd0, 1'b0, 19, 1, 1};
    tbl[3] = '{3'b110, 3'b010, 3'b001, 2'd3, 1'b0, 99, 6, 3};
    tbl[4] = '{3'b100, 3'b111, 3'b011, 2'd1, 1'b0, 19, 1, 1};
    tbl[5] = '{3'b010, 3'b000, 3'b101, 2'd0, 1'b1, 90, 0, 0};

    // Reset held, then released with no start: everything stays at zero.
    repeat (2) cycle(idle_exp(0, 1'b0));
    rst_n = 1'b1;
    idle_cycles(8);

    for (int i = 0; i < 6; i++) begin
      run_case(tbl[i], tbl[i].cont ? 1 : 0);
      idle_cycles(3);
    end

    // Start with an empty mask is ignored.
    tag_en = '0; start = 1'b1;
    cycle(idle_exp(last_rc, 1'b0));
    start = 1'b0;
    idle_cycles(3);

    // Start and stop together: stop wins.
    tag_en = 3'b111; start = 1'b1; stop = 1'b1;
    cycle(idle_exp(last_rc, 1'b0));
    start = 1'b0; stop = 1'b0;
    idle_cycles(3);

    // Stop on the fifth cycle of the first slot, then a clean restart.
    s = '{3'b011, 3'b000, 3'b100, 2'd1, 1'b0, 5, 2, 1};
    run_case(s, 1);
    idle_cycles(3);
    s.run_cycles = 35;
    run_case(s, 0);
    idle_cycles(2);

    // Reset in the middle of a run.
    s = '{3'b111, 3'b001, 3'b010, 2'd1, 1'b0, 20, 3, 1};
    run_case(s, 2);
    idle_cycles(4);

    @(negedge clk_1000);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
